// File: rtl/c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : c_pkg
//  Description : Shared types and constants for the LED-bar timer blocks
//                (fill timer c_countup and its countdown counterpart).
//  Revision    : 1.0 - initial release
// ============================================================================
package c_pkg;

    // Number of LEDs in the lab bar, shared with the countdown block.
    localparam int LED_COUNT        = 11;

    // Clock cycles per fill step: 4 Hz at a 100 MHz system clock.
    localparam int DEFAULT_TICK_DIV = 25000000;

    // Short step period so a full fill runs in a few dozen cycles in a bench.
    localparam int SIM_TICK_DIV     = 4;

    // Controller states, shared encoding for both bar timers.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : c_pkg
`default_nettype wire

// File: rtl/c_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : c_tick_gen
//  Description : Step-rate divider. Produces a one-cycle clock-enable pulse
//                every TICK_DIV enabled cycles; never a derived clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module c_tick_gen
    import c_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // TICK_DIV >= 2, so the counter is always at least one bit wide.
    localparam int                CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    // The pulse is qualified by en so a frozen counter parked at its
    // terminal value cannot fire a step while paused.
    assign w_tick = en && (r_cnt == c_CNT_MAX);
    assign tick   = w_tick;

    // Step counter: clear wins, then count 0..TICK_DIV-1 on enabled cycles.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule : c_tick_gen
`default_nettype wire

// File: rtl/c_countup.sv
`default_nettype none
// ============================================================================
//  Module      : c_countup
//  Description : LED-bar fill timer. After an accepted start it lights one
//                more LED (from bit 0 upward) per step until the bar is full,
//                then raises done until acknowledged. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module c_countup
    import c_pkg::*;
#(
    parameter int N_LEDS   = LED_COUNT,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              hold,
    input  logic              ack,
    output logic [N_LEDS-1:0] led,
    output logic              busy,
    output logic              done
);

    localparam logic [N_LEDS-1:0] c_LED_FULL = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_LEDS-1:0] r_led;
    logic [N_LEDS-1:0] w_led_nxt;
    logic              r_busy;
    logic              r_done;
    logic              w_step_en;
    logic              w_step_clr;
    logic              w_tick;

    // The divider only advances while filling and not paused; outside FILL
    // it is held at zero so every new fill starts a full step period.
    assign w_step_en  = (r_state == FILL) && !hold;
    assign w_step_clr = (r_state != FILL);

    c_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .clr     (w_step_clr),
        .en      (w_step_en),
        .tick    (w_tick)
    );

    // Next-state and next-pattern decode; outputs are derived from the
    // next state so busy/done/led change together on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        case (r_state)
            IDLE: begin
                w_led_nxt = '0;
                if (start) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (w_tick) begin
                    // Shift in one more lit LED; thermometer code from bit 0.
                    w_led_nxt = {r_led[N_LEDS-2:0], 1'b1};
                    // The step that lights the top LED ends the fill.
                    if (r_led[N_LEDS-2]) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_led_nxt = c_LED_FULL;
                // ack has priority; a start held alongside it is picked up
                // from IDLE on the following edge.
                if (ack) begin
                    w_state_nxt = IDLE;
                    w_led_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_led_nxt   = '0;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset clears them at once.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_led   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_led   <= w_led_nxt;
            r_busy  <= (w_state_nxt == FILL);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    assign led  = r_led;
    assign busy = r_busy;
    assign done = r_done;

endmodule : c_countup
`default_nettype wire

// File: tb/tb_c_countup.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c_countup
//  Description : Directed self-checking bench for the LED-bar fill timer,
//                run with the short simulation step period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_c_countup;
    import c_pkg::*;

    localparam int N = 11;

    logic         CLOCK   = 1'b0;
    logic         RESET_N = 1'b0;
    logic         start   = 1'b0;
    logic         hold    = 1'b0;
    logic         ack     = 1'b0;
    logic [N-1:0] led;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_fail   = 0;

    c_countup #(
        .N_LEDS   (N),
        .TICK_DIV (SIM_TICK_DIV)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .start   (start),
        .hold    (hold),
        .ack     (ack),
        .led     (led),
        .busy    (busy),
        .done    (done)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [N-1:0] e_led,
                             input logic e_busy, input logic e_done);
        check({tag, "_led"},  32'(led),  32'(e_led));
        check({tag, "_busy"}, 32'(busy), 32'(e_busy));
        check({tag, "_done"}, 32'(done), 32'(e_done));
    endtask

    initial begin
        // Test 1: reset state and a long idle with start low.
        #2;
        check_out("t1_in_reset", 11'h000, 1'b0, 1'b0);
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            check_out("t1_idle", 11'h000, 1'b0, 1'b0);
        end

        // Test 2: one-cycle start pulse, uninterrupted fill.
        start = 1'b1;
        step(1);                                   // edge E
        start = 1'b0;
        check_out("t2_e1", 11'h000, 1'b1, 1'b0);
        step(3);                                   // E+3
        check_out("t2_e4", 11'h000, 1'b1, 1'b0);
        step(1);                                   // E+4
        check_out("t2_e5", 11'h001, 1'b1, 1'b0);
        step(4);                                   // E+8
        check_out("t2_e9", 11'h003, 1'b1, 1'b0);
        step(35);                                  // E+43
        check_out("t2_e44", 11'h3FF, 1'b1, 1'b0);
        step(1);                                   // E+44
        check_out("t2_e45", 11'h7FF, 1'b0, 1'b1);
        // start is ignored while DONE.
        start = 1'b1;
        step(5);
        start = 1'b0;
        check_out("t2_done_hold", 11'h7FF, 1'b0, 1'b1);

        // Test 4: ack returns to IDLE, then a fresh fill.
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check_out("t4_ack", 11'h000, 1'b0, 1'b0);
        step(3);
        check_out("t4_idle", 11'h000, 1'b0, 1'b0);
        start = 1'b1;
        step(1);                                   // edge E
        start = 1'b0;
        check_out("t4_e1", 11'h000, 1'b1, 1'b0);
        step(3);
        check_out("t4_e4", 11'h000, 1'b1, 1'b0);
        step(1);
        check_out("t4_e5", 11'h001, 1'b1, 1'b0);
        step(40);                                  // E+44
        check_out("t4_e45", 11'h7FF, 1'b0, 1'b1);

        // Test 5: start and ack together in DONE; ack wins, then refill.
        start = 1'b1;
        ack   = 1'b1;
        step(1);                                   // ack edge A
        ack = 1'b0;
        check_out("t5_a1", 11'h000, 1'b0, 1'b0);
        step(1);                                   // A+1 = new start edge E
        start = 1'b0;
        check_out("t5_a2", 11'h000, 1'b1, 1'b0);

        // Test 3: hold for 10 cycles mid-fill stretches the fill by 10.
        step(10);                                  // E+10
        check_out("t3_e11", 11'h003, 1'b1, 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_out("t3_hold", 11'h003, 1'b1, 1'b0);
        end
        hold = 1'b0;                               // now E+20
        step(33);                                  // E+53
        check_out("t3_e54", 11'h3FF, 1'b1, 1'b0);
        step(1);                                   // E+54
        check_out("t3_e55", 11'h7FF, 1'b0, 1'b1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check_out("t3_ack", 11'h000, 1'b0, 1'b0);

        // Test 6: asynchronous reset between edges during a fill.
        start = 1'b1;
        step(1);                                   // edge E
        start = 1'b0;
        step(20);                                  // E+20
        check_out("t6_pre", 11'h01F, 1'b1, 1'b0);
        #3;
        RESET_N = 1'b0;
        #1;
        check_out("t6_async", 11'h000, 1'b0, 1'b0);
        step(2);
        check_out("t6_in_reset", 11'h000, 1'b0, 1'b0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_out("t6_idle", 11'h000, 1'b0, 1'b0);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_out("t6_restart", 11'h000, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_c_countup
`default_nettype wire
